// File: rtl/repsub_divider_if.sv
// repsub_divider_if: start/done handshake and result bus between a sequencer and the divider
interface repsub_divider_if #(parameter int WIDTH = 16);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             done;
  logic             dvz;
  logic             busy;
  modport master (output start, data_in, input quotient, remainder, done, dvz, busy);
  modport slave  (input start, data_in, output quotient, remainder, done, dvz, busy);
endinterface

// File: rtl/repsub_divider.sv
// repsub_divider: unsigned divider by repeated subtraction, operands loaded serially on data_in
module repsub_divider #(parameter int WIDTH = 16) (
  input logic             clk,
  input logic             rst,
  repsub_divider_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOADB, SUB, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d, d_q, d_d, q_q, q_d;
  logic             dvz_q, dvz_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      d_q     <= '0;
      q_q     <= '0;
      dvz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      d_q     <= d_d;
      q_q     <= q_d;
      dvz_q   <= dvz_d;
    end
  end
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    d_d     = d_q;
    q_d     = q_q;
    dvz_d   = dvz_q;
    case (state_q)
      IDLE, DONE: if (bus.start) begin
        r_d     = bus.data_in;
        q_d     = '0;
        dvz_d   = 1'b0;
        state_d = LOADB;
      end
      LOADB: begin
        d_d     = bus.data_in;
        state_d = SUB;
      end
      SUB: if (d_q == '0) begin
        dvz_d   = 1'b1;
        q_d     = '1;
        state_d = DONE;
      end else if (r_q >= d_q) begin
        r_d = r_q - d_q;
        q_d = q_q + 1'b1;
      end else begin
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.quotient  = q_q;
  assign bus.remainder = r_q;
  assign bus.dvz       = dvz_q;
  assign bus.done      = (state_q == DONE);
  assign bus.busy      = (state_q == LOADB) || (state_q == SUB);
endmodule

// File: tb/tb_repsub_divider.sv
// tb_repsub_divider: scoreboard bench for repsub_divider, expectations from a / and % model
module tb_repsub_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic        dvz;
    logic [31:0] lat;
    logic        busy_ok;
  } res_t;
  res_t exp_q[$];
  repsub_divider_if #(.WIDTH(16)) bus();
  repsub_divider #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b);
    res_t e;
    e.q       = (b == 16'd0) ? 16'hFFFF : a / b;
    e.r       = (b == 16'd0) ? a : a % b;
    e.dvz     = (b == 16'd0);
    e.lat     = (b == 16'd0) ? 32'd3 : 32'(e.q) + 32'd3;
    e.busy_ok = 1'b1;
    return e;
  endfunction
  // caller must be at a negedge; returns at the negedge after the start edge
  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic poke);
    bus.start   = 1'b1;
    bus.data_in = a;
    @(negedge clk);
    bus.start   = poke;
    bus.data_in = b;
    exp_q.push_back(model(a, b));
  endtask
  task automatic wait_done(input logic noise, output res_t obs);
    int cnt = 1;
    logic ok = 1'b1;
    while (!bus.done && cnt < 70000) begin
      if (!bus.busy) ok = 1'b0;
      @(negedge clk);
      cnt++;
      bus.start   = noise ? 1'($urandom) : 1'b0;
      bus.data_in = 16'($urandom);
    end
    bus.start = 1'b0;
    if (bus.busy) ok = 1'b0;
    obs = '{bus.quotient, bus.remainder, bus.dvz, 32'(cnt), ok};
  endtask
  task automatic test_reset;
    res_t obs;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    obs = '{bus.quotient, bus.remainder, bus.dvz, {30'd0, bus.done, bus.busy}, 1'b1};
    checks++;
    if (obs !== res_t'(1)) begin
      failures++;
      $display("FAIL reset: got %h want %h", obs, res_t'(1));
    end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_basic;
    res_t obs, e;
    logic [15:0] ops [3][2] = '{'{16'd100, 16'd7}, '{16'd5, 16'd9}, '{16'd0, 16'd5}};
    foreach (ops[i]) begin
      launch(ops[i][0], ops[i][1], 1'b0);
      wait_done(1'b0, obs);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL basic_%0d: got %h want %h", i, obs, e);
      end
    end
  endtask
  task automatic test_dvz;
    res_t obs, e;
    logic [15:0] ops [2][2] = '{'{16'd1234, 16'd0}, '{16'd20, 16'd4}};
    foreach (ops[i]) begin
      launch(ops[i][0], ops[i][1], 1'b0);
      wait_done(1'b0, obs);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL dvz_%0d: got %h want %h", i, obs, e);
      end
    end
  endtask
  task automatic test_boundary;
    res_t obs, e;
    logic [15:0] ops [2][2] = '{'{16'hFFFF, 16'hFFFF}, '{16'hFFFF, 16'd1}};
    foreach (ops[i]) begin
      launch(ops[i][0], ops[i][1], 1'b0);
      wait_done(1'b0, obs);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL boundary_%0d: got %h want %h", i, obs, e);
      end
    end
  endtask
  task automatic test_ignore_start_and_reset;
    res_t obs, e;
    logic [35:0] outs;
    launch(16'd100, 16'd7, 1'b1);
    wait_done(1'b1, obs);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL ignore_start: got %h want %h", obs, e);
    end
    @(negedge clk);
    launch(16'd300, 16'd3, 1'b0);
    void'(exp_q.pop_front());
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 outs = {bus.quotient, bus.remainder, bus.dvz, bus.done, bus.busy, 1'b0};
    checks++;
    if (outs !== 36'd0) begin
      failures++;
      $display("FAIL async_reset: got %h want %h", outs, 36'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    launch(16'd100, 16'd7, 1'b0);
    wait_done(1'b0, obs);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL after_reset: got %h want %h", obs, e);
    end
  endtask
  task automatic test_back_to_back;
    res_t obs, e;
    logic [33:0] held;
    launch(16'd50, 16'd5, 1'b0);
    wait_done(1'b0, obs);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL b2b_first: got %h want %h", obs, e);
    end
    repeat (2) @(negedge clk);
    held = {bus.quotient, bus.remainder, bus.done, bus.busy};
    checks++;
    if (held !== {16'd10, 16'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL b2b_hold: got %h want %h", held, {16'd10, 16'd0, 1'b1, 1'b0});
    end
    launch(16'd9, 16'd2, 1'b0);
    checks++;
    if ({bus.done, bus.busy} !== 2'b01) begin
      failures++;
      $display("FAIL b2b_drop: got done/busy %b want 01", {bus.done, bus.busy});
    end
    wait_done(1'b0, obs);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL b2b_second: got %h want %h", obs, e);
    end
  endtask
  initial begin
    bus.start   = 1'b0;
    bus.data_in = 16'd0;
    test_reset();
    test_basic();
    test_dvz();
    test_boundary();
    test_ignore_start_and_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/repsub_divider.md
# repsub_divider

Sequential unsigned integer divider using repeated subtraction. It is the inverse companion to the repeated-addition multiplier in the same arithmetic datapath family. Both operands arrive one after another on a shared `data_in` bus, using the same load sequence as the multiplier. The block returns quotient, remainder and a divide-by-zero flag under a start/done handshake, and it sits beside the multiplier as a slave arithmetic unit driven by a higher-level sequencer.

## Interface
- `WIDTH`, default 16: operand, quotient and remainder width.

Ports:
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `start`  in  1: begins an operation; sampled only in IDLE or DONE.
- `data_in`  in  WIDTH: shared operand bus; dividend on the start cycle, divisor on the next cycle.
- `quotient`  out  WIDTH: registered quotient; valid while `done`=1.
- `remainder`  out  WIDTH: registered remainder; valid while `done`=1.
- `done`  out  1: registered; high in DONE state.
- `dvz`  out  1: registered; divide-by-zero flag, valid with `done`.
- `busy`  out  1: registered; high in LOADB and SUB.

## Operation
- Internal registers:
  - R (remainder/working dividend, WIDTH)
  - D (divisor, WIDTH)
  - Q (quotient counter, WIDTH)
  - state
- States are IDLE, LOADB, SUB and DONE. All arithmetic is unsigned, modulo 2^WIDTH.
- IDLE:
  - `start`=1: R<=`data_in`, Q<=0, `dvz`<=0, go LOADB.
  - Otherwise hold.
- LOADB: D<=`data_in` unconditionally, go SUB. `start` is ignored.
- SUB, evaluated in priority order each edge:
  - D==0: `dvz`<=1, Q<=all ones, R unchanged (equals dividend), go DONE.
  - R>=D: R<=R-D, Q<=Q+1, stay in SUB.
  - Else: go DONE.
- `start` is ignored in SUB.
- Q cannot overflow: at most one increment per subtraction, and there are at most dividend/D subtractions.
- DONE:
  - `done`=1; `quotient`=Q and `remainder`=R are held indefinitely.
  - `start`=1 behaves exactly as in IDLE: captures the new dividend, clears Q and `dvz`, goes LOADB, and drops `done` at that edge.
- `quotient`/`remainder` outputs are Q and R directly. They are only guaranteed meaningful while `done`=1.
- No ack input. Results persist until the next `start` or `rst`.

## Timing
- Reset values while `rst`=1, applied asynchronously and independent of `clk`:
  - state=IDLE
  - R=D=Q=0
  - `quotient`=0, `remainder`=0
  - `done`=0, `dvz`=0, `busy`=0
- Reset mid-operation aborts the operation with no partial result retained. The first `start` after `rst` deasserts is honoured normally.
- Let edge k sample `start`=1:
  - Edge k: dividend captured.
  - Edge k+1: divisor captured.
  - Edges k+2 … k+1+N: subtractions, where N = final quotient.
  - Edge k+2+N: transition to DONE.
- Latency: `done` rises after edge k+2+N, i.e. N+3 cycles after the start edge.
- Divide-by-zero: `done` and `dvz` rise after edge k+2 (3 cycles).
- Worst case: N = 2^WIDTH-1 (divisor 1), giving 65538 cycles at WIDTH=16.
- `busy` is high from the edge after k through the edge entering DONE. `busy` and `done` are never both 1.
- `data_in` must be stable around edges k and k+1 only; it is don't-care elsewhere.

## Test plan
- 100 then 7 → `quotient`=14, `remainder`=2, `dvz`=0; `done` rises exactly 17 cycles after the start edge; `busy`=1 for the 16 cycles before.
- 5 then 9 → `quotient`=0, `remainder`=5, `done` after 3 cycles. Also 0 then 5 → Q=0, R=0, 3 cycles.
- 1234 then 0 → `dvz`=1, `quotient`=0xFFFF, `remainder`=1234, `done` after 3 cycles. The next op, 20 then 4, returns Q=5, R=0, `dvz`=0.
- 0xFFFF then 0xFFFF → Q=1, R=0 in 4 cycles. 0xFFFF then 1 → Q=0xFFFF, R=0 in 65538 cycles.
- `start` pulsed with garbage `data_in` during LOADB and SUB of 100/7 → ignored, result still 14/2. Then `rst` asserted mid-SUB of a new op, asynchronously between edges → all outputs 0 immediately. Then 100/7 after release → 14/2.
- Back-to-back:
  - In DONE of 50/5 (Q=10, R=0), `start`=1 with 9, then 2 → `done` drops at that edge.
  - Result Q=4, R=1, `done` 7 cycles later.
  - Results of 50/5 remain stable on the outputs until that edge.
